// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// pointer LUT contents and default widths.
package dm_arb_pkg;

  localparam int PTR_W_DEF = 8;
  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 8;

  // Pointers 0..LUT_ENTRIES-1 map to LUT_ADR[ptr]; everything else goes to LUT_OOR_ADR.
  localparam int LUT_ENTRIES = 5;
  localparam int LUT_ADR [LUT_ENTRIES] = '{1, 2, 3, 4, 5};
  localparam int LUT_OOR_ADR = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/dm_ptr_lut.sv
// Combinational pointer-to-address translation with an in-range flag;
// out-of-range pointers resolve to the fallback address.
module dm_ptr_lut
  import dm_arb_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic [PTR_W-1:0] ptr,
  output logic [AW-1:0]    adr,
  output logic             in_range
);

  always_comb begin
    adr      = AW'(LUT_OOR_ADR);
    in_range = 1'b0;
    for (int i = 0; i < LUT_ENTRIES; i++) begin
      if (ptr == PTR_W'(i)) begin
        adr      = AW'(LUT_ADR[i]);
        in_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory.
// Build option: DM_ARB_RR_EN selects round-robin tie-break (else port 0 wins ties).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_we,
  input  logic [PTR_W-1:0] req0_ptr,
  input  logic [DW-1:0]    req0_wdata,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_we,
  input  logic [PTR_W-1:0] req1_ptr,
  input  logic [DW-1:0]    req1_wdata,
  output logic             rsp0_valid,
  output logic [DW-1:0]    rsp0_rdata,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [DW-1:0]    rsp1_rdata,
  output logic             rsp1_err,
  output logic [AW-1:0]    dm_adr,
  output logic             dm_we,
  output logic [DW-1:0]    dm_wdata,
  input  logic [DW-1:0]    dm_rdata,
  output state_e           dbg_state
);

  // Handshake: a request transfers on the rising edge where reqk_valid && reqk_ready.
  // Ready is combinational from valid, high only in IDLE and for at most one port.

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [AW-1:0]   dm_adr_q, dm_adr_d;
  logic            dm_we_q, dm_we_d;
  logic [DW-1:0]   dm_wdata_q, dm_wdata_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [DW-1:0]   rsp1_rdata_q, rsp1_rdata_d;
  logic            rsp0_err_q, rsp0_err_d;
  logic            rsp1_err_q, rsp1_err_d;

  logic            any_req;
  logic            win;
  logic            tie_win;
  logic [PTR_W-1:0] win_ptr;
  logic [AW-1:0]   lut_adr;
  logic            lut_in_range;
  logic [DW-1:0]   rdata_cap;

`ifdef DM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;
  // The port that was not granted most recently wins a tie.
  assign tie_win = ~last_gnt_q;
`else
  assign tie_win = 1'b0;
`endif

  always_comb begin
    any_req = req0_valid | req1_valid;
    win     = (req0_valid && req1_valid) ? tie_win : req1_valid;
    win_ptr = win ? req1_ptr : req0_ptr;
  end

  assign req0_ready = (state_q == ST_IDLE) && any_req && !win;
  assign req1_ready = (state_q == ST_IDLE) && any_req && win;

  dm_ptr_lut #(
    .PTR_W (PTR_W),
    .AW    (AW)
  ) u_lut (
    .ptr      (win_ptr),
    .adr      (lut_adr),
    .in_range (lut_in_range)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    err_d        = err_q;
    dm_adr_d     = dm_adr_q;
    dm_we_d      = dm_we_q;
    dm_wdata_d   = dm_wdata_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_err_d   = rsp1_err_q;
`ifdef DM_ARB_RR_EN
    last_gnt_d   = last_gnt_q;
`endif
    rdata_cap    = we_q ? '0 : dm_rdata;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d      = win;
          we_d       = win ? req1_we : req0_we;
          err_d      = !lut_in_range;
          dm_adr_d   = lut_adr;
          dm_we_d    = win ? req1_we : req0_we;
          dm_wdata_d = win ? req1_wdata : req0_wdata;
`ifdef DM_ARB_RR_EN
          last_gnt_d = win;
`endif
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The store commits on this edge, so the strobe drops with it.
        dm_we_d = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_rdata_d = rdata_cap;
          rsp1_err_d   = err_q;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_rdata_d = rdata_cap;
          rsp0_err_d   = err_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      dm_adr_q     <= '0;
      dm_we_q      <= 1'b0;
      dm_wdata_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      err_q        <= err_d;
      dm_adr_q     <= dm_adr_d;
      dm_we_q      <= dm_we_d;
      dm_wdata_q   <= dm_wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

`ifdef DM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  assign dm_adr     = dm_adr_q;
  assign dm_we      = dm_we_q;
  assign dm_wdata   = dm_wdata_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_err   = rsp1_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, multi-cycle corner sequences and
// a randomized run checked against a transaction-level reference model.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int PTR_W = 8;
  localparam int AW    = 8;
  localparam int DW    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic             req0_we = 1'b0, req1_we = 1'b0;
  logic [PTR_W-1:0] req0_ptr = '0, req1_ptr = '0;
  logic [DW-1:0]    req0_wdata = '0, req1_wdata = '0;
  logic             rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DW-1:0]    rsp0_rdata, rsp1_rdata;
  logic [AW-1:0]    dm_adr;
  logic             dm_we;
  logic [DW-1:0]    dm_wdata;
  logic [DW-1:0]    dm_rdata;
  state_e           dbg_state;

  dm_arbiter #(.PTR_W(PTR_W), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_ptr   (req0_ptr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_ptr   (req1_ptr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .dm_adr     (dm_adr),
    .dm_we      (dm_we),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dbg_state  (dbg_state)
  );

  // Synchronous-read single-port memory attached to the DUT.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (dm_we) mem[dm_adr] <= dm_wdata;
    dm_rdata <= mem[dm_adr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  logic [DW-1:0] model_mem [256];

  task automatic mem_init();
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hA5;
    for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
  endtask

  task automatic drive(input bit port, input bit v, input bit we, input logic [7:0] ptr,
                       input logic [7:0] wd);
    if (port) begin
      req1_valid = v; req1_we = we; req1_ptr = ptr; req1_wdata = wd;
    end else begin
      req0_valid = v; req0_we = we; req0_ptr = ptr; req0_wdata = wd;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] ptr;
    logic [7:0] wdata;
    logic [7:0] exp_adr;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  // Called just after a rising edge with the DUT idle; returns in the response cycle.
  task automatic run_txn(input vec_t v);
    drive(v.port, 1'b1, v.we, v.ptr, v.wdata);
    @(negedge clk);
    chk("accept_ready_win",  v.port ? req1_ready : req0_ready, 1);
    chk("accept_ready_lose", v.port ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t1_dm_adr", dm_adr, v.exp_adr);
    chk("t1_dm_we", dm_we, v.we);
    if (v.we) chk("t1_dm_wdata", dm_wdata, v.wdata);
    chk("t1_rsp_quiet", {rsp1_valid, rsp0_valid}, 0);
    @(posedge clk); #1;
    chk("t2_dm_we", dm_we, 0);
    chk("t2_rsp_quiet", {rsp1_valid, rsp0_valid}, 0);
    @(posedge clk); #1;
    chk("t3_rsp_valid", {rsp1_valid, rsp0_valid}, v.port ? 2'b10 : 2'b01);
    chk("t3_rsp_rdata", v.port ? rsp1_rdata : rsp0_rdata, v.exp_rdata);
    chk("t3_rsp_err", v.port ? rsp1_err : rsp0_err, v.exp_err);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    int         at;
    bit         port;
    logic [7:0] data;
    bit         err;
  } exp_rsp_t;

  exp_rsp_t   rsp_q[$];
  int         cyc, free_at, dm_at;
  bit         model_last;
  bit         exp_we;
  logic [7:0] exp_adr, exp_wd;
  bit         hold [2];
  bit         h_we [2];
  logic [7:0] h_ptr [2];
  logic [7:0] h_wd [2];

  task automatic model_step();
    bit idle, any, g;
    logic [7:0] adr, data;
    bit err;
    exp_rsp_t e;
    idle = (cyc >= free_at);
    any  = idle && (hold[0] || hold[1]);
    if (hold[0] && hold[1]) begin
`ifdef DM_ARB_RR_EN
      g = (model_last == 1'b0);
`else
      g = 1'b0;
`endif
    end else begin
      g = hold[1];
    end
    chk("rnd_ready0", req0_ready, any && !g);
    chk("rnd_ready1", req1_ready, any && g);

    if (rsp_q.size() > 0 && rsp_q[0].at == cyc) begin
      e = rsp_q.pop_front();
      chk("rnd_rsp_valid", {rsp1_valid, rsp0_valid}, e.port ? 2'b10 : 2'b01);
      chk("rnd_rsp_rdata", e.port ? rsp1_rdata : rsp0_rdata, e.data);
      chk("rnd_rsp_err", e.port ? rsp1_err : rsp0_err, e.err);
    end else begin
      chk("rnd_rsp_quiet", {rsp1_valid, rsp0_valid}, 0);
    end

    if (cyc == dm_at) begin
      chk("rnd_dm_adr", dm_adr, exp_adr);
      chk("rnd_dm_we", dm_we, exp_we);
      if (exp_we) chk("rnd_dm_wdata", dm_wdata, exp_wd);
    end else begin
      chk("rnd_dm_we_idle", dm_we, 0);
    end

    if (any) begin
      err = (h_ptr[g] > 8'd4);
      adr = err ? 8'd0 : h_ptr[g] + 8'd1;
      if (h_we[g]) begin
        model_mem[adr] = h_wd[g];
        data = 8'h00;
      end else begin
        data = model_mem[adr];
      end
      e.at = cyc + 3; e.port = g; e.data = data; e.err = err;
      rsp_q.push_back(e);
      dm_at = cyc + 1; exp_adr = adr; exp_we = h_we[g]; exp_wd = h_wd[g];
      free_at = cyc + 3;
      model_last = g;
      hold[g] = 1'b0;
    end
  endtask

  task automatic apply_holds();
    for (int k = 0; k < 2; k++) drive(k[0], hold[k], h_we[k], h_ptr[k], h_wd[k]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int got, grant_seq [4], waited;
    bit found;

    vecs[0] = '{1'b0, 1'b0, 8'd2,   8'h00, 8'd3, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'd4,   8'h3C, 8'd5, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'd4,   8'h00, 8'd5, 8'h3C, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'd7,   8'h00, 8'd0, 8'h11, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'd0,   8'h00, 8'd1, 8'h22, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'd200, 8'h77, 8'd0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'd5,   8'h00, 8'd0, 8'h77, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'd1,   8'h00, 8'd2, 8'h33, 1'b0};

    mem_init();
    do_reset();

    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_dm_adr", dm_adr, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp_rdata", {rsp1_rdata, rsp0_rdata}, 0);
    chk("rst_rsp_err", {rsp1_err, rsp0_err}, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset while a load sits in ACCESS: everything clears, no response follows.
    drive(1'b0, 1'b1, 1'b0, 8'd2, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    chk("mid_state_access", 32'(dbg_state), 32'(ST_ACCESS));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_dm_adr", dm_adr, 0);
    chk("mid_rst_dm_we", dm_we, 0);
    chk("mid_rst_dm_wdata", dm_wdata, 0);
    chk("mid_rst_rsp", {rsp1_valid, rsp0_valid, rsp1_rdata, rsp0_rdata, rsp1_err, rsp0_err}, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {rsp1_valid, rsp0_valid}, 0);
      @(posedge clk); #1;
    end
    run_txn('{1'b0, 1'b0, 8'd3, 8'h00, 8'd4, init_val(4), 1'b0});

    // Port 1 waits through ACCESS/WAIT and is taken in the cycle of port 0's response.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'd1, 8'h00);
    @(negedge clk);
    chk("busy_ready_access", {req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_ready_wait", {req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    chk("busy_rsp0_valid", {rsp1_valid, rsp0_valid}, 2'b01);
    chk("busy_rsp0_rdata", rsp0_rdata, 8'h22);
    @(negedge clk);
    chk("busy_ready1_on_rsp", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00);
    chk("busy_t1_adr", dm_adr, 8'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_rsp1_valid", {rsp1_valid, rsp0_valid}, 2'b10);
    chk("busy_rsp1_rdata", rsp1_rdata, 8'h33);

    // Four back-to-back ties from reset.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'd1, 8'h00);
    for (int n = 0; n < 4; n++) begin
      found = 1'b0;
      waited = 0;
      while (!found && waited < 8) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          found = 1'b1;
          got = int'(req1_ready);
          chk("tie_one_ready", {req1_ready, req0_ready} == 2'b11, 0);
        end
        @(posedge clk); #1;
        waited++;
      end
      if (!found) chk("tie_timeout", 0, 1);
      grant_seq[n] = found ? got : -1;
`ifdef DM_ARB_RR_EN
      chk("tie_grant", grant_seq[n], n % 2);
`else
      chk("tie_grant", grant_seq[n], 0);
`endif
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00);
    repeat (4) @(posedge clk);
    #1;

    // Randomized run against the reference model.
    mem_init();
    do_reset();
    cyc = 0; free_at = 0; dm_at = -1; model_last = 1'b1;
    rsp_q.delete();
    for (int k = 0; k < 2; k++) hold[k] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          if ($urandom_range(0, 2) != 0) begin
            hold[k]  = 1'b1;
            h_we[k]  = 1'($urandom_range(0, 1));
            h_ptr[k] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 9));
            h_wd[k]  = 8'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          hold[k] = 1'b0;
        end
      end
      apply_holds();
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
      cyc++;
    end
    for (int k = 0; k < 2; k++) hold[k] = 1'b0;
    apply_holds();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
      cyc++;
    end
    chk("rnd_all_responses_seen", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the single-ported data memory. It accepts load/store requests from two requesters: port 0 is the core's load/store stage and port 1 is the init/loader engine. Each request carries a small pointer, which is translated to a data-memory address through a pointer lookup table. The block serializes accesses onto the one memory port and returns read data with a one-cycle valid pulse.

## Interface
- PTR_W, 8, request pointer width
- AW, 8, data-memory address width
- DW, 8, data width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending on port k
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_we / req1_we  in  1  1 = store, 0 = load
- req0_ptr / req1_ptr  in  PTR_W  pointer, translated via LUT
- req0_wdata / req1_wdata  in  DW  store data
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse
- rsp0_rdata / rsp1_rdata  out  DW  load data; 0 for stores
- rsp0_err / rsp1_err  out  1  pointer was outside LUT range (qualified by rsp_valid)
- dm_adr  out  AW  memory address (registered)
- dm_we  out  1  memory write enable (registered)
- dm_wdata  out  DW  memory write data (registered)
- dm_rdata  in  DW  memory read data; synchronous read, valid the cycle after dm_adr is presented

## Operation
- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - If any reqk_valid, pick a winner and assert its reqk_ready combinationally.
  - At the clock edge, latch gnt, we, wdata, err, and the LUT address into dm_adr/dm_we/dm_wdata. Go to ACCESS.
  - Stay in IDLE if no request is valid.
- ACCESS: memory sees the address/we. A store commits at the end of this cycle. dm_we clears on the exit edge. Go to WAIT.
- WAIT: capture dm_rdata (loads) or 0 (stores) into rsp_rdata of the granted port. Pulse rspk_valid on the exit edge. Go to IDLE.
- LUT map:
  - ptr 0→1, 1→2, 2→3, 3→4, 4→5.
  - Any other ptr → address 0, with err=1 for that transaction.
  - The access is still performed at address 0.
- Only one reqk_ready is high in any cycle. Both readies are low outside IDLE.
- Arbitration when both ports are valid in IDLE: round-robin. The port not granted last wins. The last-granted register resets to 1, so port 0 wins the first tie.
- A requester must hold valid, we, ptr and wdata stable until ready. Dropping valid before ready is legal; nothing is issued.

## Timing
- Accept edge = T0. ACCESS during T1. dm_rdata valid during T2. rspk_valid high during T3 for exactly one cycle.
- Throughput is one transaction per 3 cycles. A new request may be accepted in the same cycle rspk_valid is high.
- Reset values: state=IDLE, dm_adr=0, dm_we=0, dm_wdata=0, rsp*_valid=0, rsp*_rdata=0, rsp*_err=0, last_gnt=1.
- Reset asserted mid-transaction:
  - Outputs clear immediately and the in-flight access is dropped; no rsp pulse follows.
  - A store caught in ACCESS may or may not have been written.

## Configuration
- DM_ARB_RR_EN defined: round-robin tie-break as above.
- DM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties, and the last_gnt register is not built.
- Both modes have identical latency and reset behaviour.

## Structure
- Shared package dm_arb_pkg holds:
  - the state enum;
  - the LUT constants (entry count 5, out-of-range address 0);
  - the DW/AW defaults.
- One sub-module, dm_ptr_lut: combinational ptr→address plus in-range flag. It is instantiated once, on the winner's ptr (muxed by grant).

## Test plan
- Port 0 load, ptr=2, memory[3]=0xA5 → dm_adr=3 in T1, rsp0_valid in T3 with rsp0_rdata=0xA5, err=0.
- Port 1 store, ptr=4, wdata=0x3C → dm_we=1, dm_adr=5 for one cycle; rsp1_valid in T3 with rdata=0; later port 0 load ptr=4 returns 0x3C.
- Both valid for 4 back-to-back transactions with RR_EN → grants 0,1,0,1; without the macro → 0,0,0,0 while port 0 stays valid.
- ptr=7 load → dm_adr=0, rsp err=1, data = memory[0].
- reset_n low during ACCESS → all outputs 0 at once, no rsp pulse, and the first transaction after release is accepted normally.
- Request held valid while busy → ready stays low in ACCESS/WAIT, then is accepted in the IDLE cycle coincident with the previous rsp_valid.
